fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; produces the iInstruction word consumed by the decode/control path.
//  Holds the PC and issues single-outstanding requests to instruction memory (req/ack).
//  Presents each fetched word with its PC to decode and takes back the decode verdict
//  (PCSrc + ImmExt) to form the next PC. Supports decode stall and external flush/redirect.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  NOP_INSTR   32'h0000_0013  value of oInstruction while no valid word held (addi x0,x0,0)
// PORTS
//  iClk           in   1   clock
//  iRst           in   1   synchronous active-high reset
//  oImemReq       out  1   fetch request to instruction memory
//  oImemAddr      out  32  fetch address, stable while oImemReq=1
//  iImemAck       in   1   memory returns iImemRdata this cycle; completes request
//  iImemRdata     in   32  instruction word
//  oInstruction   out  32  held instruction for decode
//  oPC            out  32  PC of oInstruction
//  oValid         out  1   oInstruction/oPC are valid
//  iStall         in   1   decode cannot consume this cycle
//  iPCSrc         in   1   decode: branch/jump taken for held instruction
//  iImmExt        in   32  decode: PC-relative offset for held instruction
//  iFlush         in   1   external redirect (trap/restart)
//  iFlushPC       in   32  redirect target
//  oMisaligned    out  1   misaligned next-PC fault (MISALIGN_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  Reset (iRst=1 at edge): state=FETCH_START, oImemReq=0, oImemAddr=RESET_PC, oValid=0,
//   oInstruction=NOP_INSTR, oPC=RESET_PC, oMisaligned=0. Reset dominates every other input.
//  All outputs registered. Consume = oValid & ~iStall & ~iFlush.
//  Req/ack protocol: once oImemReq=1, oImemReq and oImemAddr hold until the cycle iImemAck=1;
//   that edge completes it. At most one request outstanding. iImemAck while oImemReq=0 ignored.
//  States:
//   FETCH_START: next edge -> FETCH, oImemReq=1, oImemAddr=RESET_PC (first req 1 cycle after reset release).
//   FETCH: waiting ack. On ack edge: oInstruction=iImemRdata, oPC=oImemAddr, oValid=1,
//     oImemReq=0 -> VALID. iFlush here -> DRAIN, latch iFlushPC (request kept high until ack).
//   VALID: holding word. iFlush: oValid=0, oImemReq=1, oImemAddr=iFlushPC -> FETCH.
//     Else consume: next = iPCSrc ? oPC+iImmExt : oPC+4; oValid=0, oImemReq=1,
//     oImemAddr=next -> FETCH. Else (stall) hold all outputs; iPCSrc/iImmExt ignored.
//   DRAIN: on ack, discard iImemRdata (oValid stays 0), oImemAddr=latched flush PC, oImemReq=1 -> FETCH.
//     Further iFlush in DRAIN overwrites latched PC (last wins).
//  Priority: iRst > iFlush > consume > stall.
//  Latency: ack at edge N -> oValid=1 after N; consume at edge N+1 -> next oImemReq=1 after N+1.
//   Zero-wait memory (ack in first req cycle) yields one instruction per 2 cycles.
//  Arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 = 32'h0000_0000; offset add wraps silently.
//  oInstruction returns to NOP_INSTR whenever oValid falls.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined: if computed next PC (consume or flush) has [1:0]!=0, no request
//   is issued; state FAULT, oMisaligned=1, oPC=offending PC, oValid=0; FAULT exits only on iFlush
//   with aligned iFlushPC (-> FETCH) or reset. Flush to misaligned PC from DRAIN also -> FAULT.
//  Not defined: next PC bits [1:0] forced to 2'b00 before use; oMisaligned constant 0; no FAULT state.
// TESTING
//  Reset release, ack after 2 cycles with 32'h0050_0093 -> req addr 0x0 1 cycle after release, oValid=1, oPC=0x0.
//  Sequential, zero-wait mem, iPCSrc=0 -> request addresses 0x0,0x4,0x8,0xC, one oValid every 2 cycles.
//  Held PC 0x100, iPCSrc=1, iImmExt=32'hFFFF_FFF0 -> next oImemAddr=0xF0; stall 3 cycles first -> outputs frozen, addr still 0xF0.
//  iFlush (iFlushPC=0x200) while req to 0x40 outstanding, ack 3 cycles later -> returned word never valid, next req 0x200.
//  oPC=32'hFFFF_FFFC consumed, iPCSrc=0 -> oImemAddr=0x0; iFlush same cycle as consume -> flush PC wins.
//  MISALIGN_CHECK_EN: oPC=0x10, iPCSrc=1, iImmExt=0x2 -> oMisaligned=1, oPC=0x12, no req; iFlush 0x80 -> req 0x80, oMisaligned=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding imem req/ack, applies decode redirect.
// Optional MISALIGN_CHECK_EN traps a misaligned next PC in FAULT instead of masking bits [1:0].
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        iClk,
  input  logic        iRst,
  output logic        oImemReq,
  output logic [31:0] oImemAddr,
  input  logic        iImemAck,
  input  logic [31:0] iImemRdata,
  output logic [31:0] oInstruction,
  output logic [31:0] oPC,
  output logic        oValid,
  input  logic        iStall,
  input  logic        iPCSrc,
  input  logic [31:0] iImmExt,
  input  logic        iFlush,
  input  logic [31:0] iFlushPC,
  output logic        oMisaligned
);

  typedef enum logic [2:0] {
    FETCH_START,
    FETCH,
    VALID,
    DRAIN
`ifdef MISALIGN_CHECK_EN
    , FAULT
`endif
  } state_e;

  state_e      state_q, state_d, redirState;
  logic        req_q, req_d, valid_q, valid_d;
  logic [31:0] addr_q, addr_d, instr_q, instr_d, pc_q, pc_d, flushPc_q, flushPc_d;
  logic        consume, redirect;
  logic [31:0] rawTgt, tgt;
`ifdef MISALIGN_CHECK_EN
  logic        tgtBad, misaligned_q, misaligned_d;
`endif

  // Redirect target: decode verdict while holding a word, the latched flush PC when draining, else iFlushPC.
  always_comb begin
    consume = valid_q & ~iStall & ~iFlush;
    if (state_q == VALID && !iFlush) begin
      rawTgt = iPCSrc ? pc_q + iImmExt : pc_q + 32'd4;
    end else if (state_q == DRAIN && !iFlush) begin
      rawTgt = flushPc_q;
    end else begin
      rawTgt = iFlushPC;
    end
    redirect = 1'b0;
    case (state_q)
      FETCH_START: redirect = iFlush;
      FETCH:       redirect = iImemAck & iFlush;
      VALID:       redirect = iFlush | consume;
      DRAIN:       redirect = iImemAck;
`ifdef MISALIGN_CHECK_EN
      FAULT:       redirect = iFlush & ~tgtBad;
`endif
      default:     redirect = 1'b0;
    endcase
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    tgt        = rawTgt;
    tgtBad     = |rawTgt[1:0];
    redirState = tgtBad ? FAULT : FETCH;
  end
`else
  always_comb begin
    tgt        = rawTgt & 32'hFFFF_FFFC;
    redirState = FETCH;
  end
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= FETCH_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_START: state_d = redirect ? redirState : FETCH;
      FETCH: begin
        if (iImemAck) begin
          state_d = redirect ? redirState : VALID;
        end else if (iFlush) begin
          state_d = DRAIN;
        end
      end
      VALID:   if (redirect) state_d = redirState;
      DRAIN:   if (redirect) state_d = redirState;
`ifdef MISALIGN_CHECK_EN
      FAULT:   if (redirect) state_d = FETCH;
`endif
      default: state_d = FETCH_START;
    endcase
  end

  // Every output is a register; this block computes their next values.
  always_comb begin
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    flushPc_d = flushPc_q;
`ifdef MISALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    case (state_q)
      FETCH_START: begin
        req_d  = 1'b1;
        addr_d = RESET_PC;
      end
      FETCH: begin
        if (iImemAck && !iFlush) begin
          instr_d = iImemRdata;
          pc_d    = addr_q;
          valid_d = 1'b1;
          req_d   = 1'b0;
        end else if (!iImemAck && iFlush) begin
          flushPc_d = iFlushPC;
        end
      end
      DRAIN:   if (iFlush) flushPc_d = iFlushPC;
      default: ;
    endcase
    if (redirect) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      req_d   = 1'b1;
      addr_d  = tgt;
`ifdef MISALIGN_CHECK_EN
      misaligned_d = 1'b0;
      if (tgtBad) begin
        req_d        = 1'b0;
        addr_d       = addr_q;
        pc_d         = tgt;
        misaligned_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      flushPc_q <= RESET_PC;
    end else begin
      req_q     <= req_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      flushPc_q <= flushPc_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end
  assign oMisaligned = misaligned_q;
`else
  assign oMisaligned = 1'b0;
`endif

  assign oImemReq     = req_q;
  assign oImemAddr    = addr_q;
  assign oInstruction = instr_q;
  assign oPC          = pc_q;
  assign oValid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus a zero-wait streaming sequence.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        iRst = 1'b1, iImemAck = 1'b0, iStall = 1'b0, iPCSrc = 1'b0, iFlush = 1'b0;
  logic [31:0] iImemRdata = '0, iImmExt = '0, iFlushPC = '0;
  logic        oImemReq, oValid, oMisaligned;
  logic [31:0] oImemAddr, oInstruction, oPC;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .iClk(clk), .iRst(iRst),
    .oImemReq(oImemReq), .oImemAddr(oImemAddr), .iImemAck(iImemAck), .iImemRdata(iImemRdata),
    .oInstruction(oInstruction), .oPC(oPC), .oValid(oValid),
    .iStall(iStall), .iPCSrc(iPCSrc), .iImmExt(iImmExt),
    .iFlush(iFlush), .iFlushPC(iFlushPC), .oMisaligned(oMisaligned)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        pcSrc;
    logic [31:0] imm;
    logic        flush;
    logic [31:0] flushPc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expMis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic stall, logic pcSrc,
                              logic [31:0] imm, logic flush, logic [31:0] fpc, logic req,
                              logic [31:0] addr, logic valid, logic [31:0] instr, logic [31:0] pc,
                              logic mis);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.stall = stall; v.pcSrc = pcSrc; v.imm = imm;
    v.flush = flush; v.flushPc = fpc; v.expReq = req; v.expAddr = addr; v.expValid = valid;
    v.expInstr = instr; v.expPc = pc; v.expMis = mis;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    iRst = v.rst; iImemAck = v.ack; iImemRdata = v.rdata; iStall = v.stall;
    iPCSrc = v.pcSrc; iImmExt = v.imm; iFlush = v.flush; iFlushPC = v.flushPc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checks++;
    if (oImemReq !== v.expReq || oImemAddr !== v.expAddr || oValid !== v.expValid ||
        oInstruction !== v.expInstr || oPC !== v.expPc || oMisaligned !== v.expMis) begin
      errors++;
      $display("[TB] FAIL vec%0d req/addr/valid/instr/pc/mis got %b/%h/%b/%h/%h/%b expected %b/%h/%b/%h/%h/%b",
               idx, oImemReq, oImemAddr, oValid, oInstruction, oPC, oMisaligned,
               v.expReq, v.expAddr, v.expValid, v.expInstr, v.expPc, v.expMis);
    end
  endtask

  initial begin
    logic [31:0] expReq, expPc;
    int          validSeen, lastValidCycle;
    logic        prevReq;

    // Columns: rst ack rdata stall pcSrc imm flush flushPc | req addr valid instr pc mis
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0, NOP, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0, NOP, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0050_0093, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h0050_0093, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h4, 1'b0, NOP, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0010_0113, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h4, 1'b1, 32'h0010_0113, 32'h4, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h8, 1'b0, NOP, 32'h4, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0020_0193, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h8, 1'b1, 32'h0020_0193, 32'h8, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'hC, 1'b0, NOP, 32'h8, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h0030_0213, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'hC, 1'b1, 32'h0030_0213, 32'hC, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100,  1'b1, 32'h100, 1'b0, NOP, 32'hC, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h100, 1'b1, 32'h1111_1111, 32'h100, 1'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0,  1'b0, 32'h100, 1'b1, 32'h1111_1111, 32'h100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0,  1'b1, 32'hF0, 1'b0, NOP, 32'h100, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'hF0, 1'b1, 32'h2222_2222, 32'hF0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF50, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, NOP, 32'hF0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200,  1'b1, 32'h40, 1'b0, NOP, 32'hF0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, NOP, 32'hF0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, NOP, 32'hF0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h200, 1'b0, NOP, 32'hF0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h200, 1'b1, 32'h4444_4444, 32'h200, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC,  1'b1, 32'hFFFF_FFFC, 1'b0, NOP, 32'h200, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'hFFFF_FFFC, 1'b1, 32'h5555_5555, 32'hFFFF_FFFC, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0, 1'b0, NOP, 32'hFFFF_FFFC, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h6666_6666, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 32'h6666_6666, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h300,  1'b1, 32'h300, 1'b0, NOP, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h300, 1'b1, 32'h7777_7777, 32'h300, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h304, 1'b0, NOP, 32'h300, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500,  1'b1, 32'h304, 1'b0, NOP, 32'h300, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600,  1'b1, 32'h304, 1'b0, NOP, 32'h300, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h8888_8888, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h600, 1'b0, NOP, 32'h300, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'h9999_9999, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h600, 1'b1, 32'h9999_9999, 32'h600, 1'b0));
`ifdef MISALIGN_CHECK_EN
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12, 1'b0, 32'h0,  1'b0, 32'h600, 1'b0, NOP, 32'h612, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h600, 1'b0, NOP, 32'h612, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80,  1'b1, 32'h80, 1'b0, NOP, 32'h612, 1'b0));
`else
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12, 1'b0, 32'h0,  1'b1, 32'h610, 1'b0, NOP, 32'h600, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h610, 1'b1, 32'hAAAA_AAAA, 32'h610, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h83,  1'b1, 32'h80, 1'b0, NOP, 32'h610, 1'b0));
`endif
    vecs.push_back(mk(1'b0, 1'b1, 32'hBBBB_BBBB, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h80, 1'b1, 32'hBBBB_BBBB, 32'h80, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900,  1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Zero-wait memory from reset: requests 0,4,8,C and one valid word every second cycle.
    expReq = 32'h0;
    expPc = 32'h0;
    validSeen = 0;
    lastValidCycle = -1;
    prevReq = 1'b0;
    for (int cyc = 0; cyc < 40 && validSeen < 4; cyc++) begin
      @(negedge clk);
      iRst = 1'b0; iImemAck = 1'b1; iImemRdata = oImemAddr ^ 32'hA5A5_0000;
      iStall = 1'b0; iPCSrc = 1'b0; iFlush = 1'b0;
      @(posedge clk);
      #1;
      if (oImemReq && !prevReq) begin
        checks++;
        if (oImemAddr !== expReq) begin
          errors++;
          $display("[TB] FAIL stream_req addr got %h expected %h", oImemAddr, expReq);
        end
        expReq = expReq + 32'd4;
      end
      prevReq = oImemReq;
      if (oValid) begin
        checks++;
        if (oPC !== expPc || oInstruction !== (expPc ^ 32'hA5A5_0000) ||
            (lastValidCycle >= 0 && cyc - lastValidCycle != 2)) begin
          errors++;
          $display("[TB] FAIL stream_valid pc/instr/gap got %h/%h/%0d expected %h/%h/2",
                   oPC, oInstruction, cyc - lastValidCycle, expPc, expPc ^ 32'hA5A5_0000);
        end
        lastValidCycle = cyc;
        expPc = expPc + 32'd4;
        validSeen++;
      end
    end
    checks++;
    if (validSeen != 4) begin
      errors++;
      $display("[TB] FAIL stream_timeout valid words got %0d expected 4", validSeen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
